// File: rtl/qrd_pkg.sv
// Shared QRD definitions: default sizes, element and skew-stage record types, array beat period.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package qrd_pkg;

  localparam int DEF_WIDTH = 14;  // real/imag component width
  localparam int DEF_COLS  = 4;   // columns per matrix
  localparam int ITER      = 26;  // array beat period in clk cycles

  // One complex matrix element
  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] r;
    logic signed [DEF_WIDTH-1:0] i;
  } cplx_t;

  // One skew pipeline slot: data plus first-column tag and a "not a bubble" marker
  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] r;
    logic signed [DEF_WIDTH-1:0] i;
    logic                        first;
    logic                        is_real;
  } skew_stage_t;

endpackage

// File: rtl/qrd_col_fifo.sv
// Synchronous show-ahead FIFO holding whole matrix columns.
// Latency: a pushed word is visible on rd_data the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; full/empty are registered-pointer derived.
module qrd_col_fifo #(
  parameter int DW    = 112,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; stale words are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/qrd_input_skewer.sv
// Buffers incoming columns and feeds the QRD array rows with a diagonal skew (row k lags k-1 beats); optional QRD_SKEW_BUBBLE_CNT_EN adds bubble_cnt.
// Latency: row k of a popped column reaches the outputs after k advances counting the pop edge.
// Backpressure: s_ready = FIFO not full (no pass-through on a full-cycle pop); an empty FIFO on a beat injects a bubble.
module qrd_input_skewer
  import qrd_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int COLS       = DEF_COLS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_col_1_r,
  input  logic [WIDTH-1:0] s_col_1_i,
  input  logic [WIDTH-1:0] s_col_2_r,
  input  logic [WIDTH-1:0] s_col_2_i,
  input  logic [WIDTH-1:0] s_col_3_r,
  input  logic [WIDTH-1:0] s_col_3_i,
  input  logic [WIDTH-1:0] s_col_4_r,
  input  logic [WIDTH-1:0] s_col_4_i,
  input  logic             qrd_ready,
  output logic [WIDTH-1:0] row_in_1_r,
  output logic [WIDTH-1:0] row_in_1_i,
  output logic [WIDTH-1:0] row_in_2_r,
  output logic [WIDTH-1:0] row_in_2_i,
  output logic [WIDTH-1:0] row_in_3_r,
  output logic [WIDTH-1:0] row_in_3_i,
  output logic [WIDTH-1:0] row_in_4_r,
  output logic [WIDTH-1:0] row_in_4_i,
  output logic             row_in_1_f,
  output logic             row_in_2_f,
  output logic             row_in_3_f,
  output logic             busy
`ifdef QRD_SKEW_BUBBLE_CNT_EN
  , output logic [15:0]    bubble_cnt
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] i;
    logic             first;
    logic             is_real;
  } stage_t;

  logic [8*WIDTH-1:0] wr_col;
  logic [8*WIDTH-1:0] rd_col;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [CW-1:0]      col_cnt;
  stage_t             in_s [4];

  // Output registers o1..o4 and delay stages dK_n (row K, n-th stage from the input)
  stage_t o1, o2, o3, o4;
  stage_t d2_1, d3_1, d3_2, d4_1, d4_2, d4_3;

  // Element k occupies slot k-1; real part in the upper half of each slot
  assign wr_col = {s_col_4_r, s_col_4_i, s_col_3_r, s_col_3_i,
                   s_col_2_r, s_col_2_i, s_col_1_r, s_col_1_i};

  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign pop     = qrd_ready && !empty;

  qrd_col_fifo #(
    .DW    (8*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_col),
    .pop     (pop),
    .rd_data (rd_col),
    .full    (full),
    .empty   (empty)
  );

  // Split the head column into tagged slots, or a zero bubble when nothing is popped
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_s[k] = '0;
      if (pop) begin
        in_s[k].r       = rd_col[k*2*WIDTH+WIDTH +: WIDTH];
        in_s[k].i       = rd_col[k*2*WIDTH +: WIDTH];
        in_s[k].first   = (col_cnt == '0);
        in_s[k].is_real = 1'b1;
      end
    end
  end

  // Skew pipeline and column counter move only on an array beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o1 <= '0; o2 <= '0; o3 <= '0; o4 <= '0;
      d2_1 <= '0; d3_1 <= '0; d3_2 <= '0;
      d4_1 <= '0; d4_2 <= '0; d4_3 <= '0;
      col_cnt <= '0;
    end else if (qrd_ready) begin
      o1   <= in_s[0];
      d2_1 <= in_s[1]; o2 <= d2_1;
      d3_1 <= in_s[2]; d3_2 <= d3_1; o3 <= d3_2;
      d4_1 <= in_s[3]; d4_2 <= d4_1; d4_3 <= d4_2; o4 <= d4_3;
      if (!empty) col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + CNT_ONE;
    end
  end

`ifdef QRD_SKEW_BUBBLE_CNT_EN
  // Count bubbles that starve a matrix mid-stream; saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (qrd_ready && empty && (col_cnt != '0) && (bubble_cnt != 16'hFFFF))
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

  assign row_in_1_r = o1.r;
  assign row_in_1_i = o1.i;
  assign row_in_2_r = o2.r;
  assign row_in_2_i = o2.i;
  assign row_in_3_r = o3.r;
  assign row_in_3_i = o3.i;
  assign row_in_4_r = o4.r;
  assign row_in_4_i = o4.i;
  assign row_in_1_f = o1.first;
  assign row_in_2_f = o2.first;
  assign row_in_3_f = o3.first;

  // Row 4 first bit is intentionally unused beyond being carried; only is_real matters for busy
  assign busy = !empty
             || o1.is_real || o2.is_real || o3.is_real || o4.is_real
             || d2_1.is_real || d3_1.is_real || d3_2.is_real
             || d4_1.is_real || d4_2.is_real || d4_3.is_real
             || (o4.first && 1'b0);

endmodule

// File: tb/tb_qrd_input_skewer.sv
// Directed self-checking bench for qrd_input_skewer.
// Latency: outputs sampled 1 ns after each rising clk edge.
// Backpressure: exercised by filling the FIFO with qrd_ready held low.
module tb_qrd_input_skewer;
  import qrd_pkg::*;

  localparam int W = DEF_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic qrd_ready = 1'b0;
  logic s_ready;
  logic busy;
  logic signed [W-1:0] col_r [4];
  logic signed [W-1:0] col_i [4];
  logic signed [W-1:0] row_r [4];
  logic signed [W-1:0] row_i [4];
  logic row_f [3];
`ifdef QRD_SKEW_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qrd_input_skewer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_col_1_r  (col_r[0]), .s_col_1_i (col_i[0]),
    .s_col_2_r  (col_r[1]), .s_col_2_i (col_i[1]),
    .s_col_3_r  (col_r[2]), .s_col_3_i (col_i[2]),
    .s_col_4_r  (col_r[3]), .s_col_4_i (col_i[3]),
    .qrd_ready  (qrd_ready),
    .row_in_1_r (row_r[0]), .row_in_1_i (row_i[0]),
    .row_in_2_r (row_r[1]), .row_in_2_i (row_i[1]),
    .row_in_3_r (row_r[2]), .row_in_3_i (row_i[2]),
    .row_in_4_r (row_r[3]), .row_in_4_i (row_i[3]),
    .row_in_1_f (row_f[0]),
    .row_in_2_f (row_f[1]),
    .row_in_3_f (row_f[2]),
    .busy       (busy)
`ifdef QRD_SKEW_BUBBLE_CNT_EN
    , .bubble_cnt (bubble_cnt)
`endif
  );

  // Element k (0-based) of column c is (c*10+k+1, -(c*10+k+1)); out-of-range c means a bubble
  function automatic logic signed [W-1:0] ev(input int c, input int k, input int ncols);
    if (c < 0 || c >= ncols) return '0;
    return W'(c*10 + k + 1);
  endfunction

  function automatic logic ef(input int c, input int ncols);
    return (c >= 0) && (c < ncols) && (c % 4 == 0);
  endfunction

  task automatic drive_col(input int c);
    for (int k = 0; k < 4; k++) begin
      col_r[k] = W'(c*10 + k + 1);
      col_i[k] = -col_r[k];
    end
  endtask

  task automatic tick(input logic qr, input logic pv);
    qrd_ready = qr;
    s_valid   = pv;
    @(posedge clk);
    #1;
    qrd_ready = 1'b0;
    s_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      tick(logic'(t % 2 == 0), 1'b0);
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (row_r[k] !== '0 || row_i[k] !== '0) begin
          n_bad++;
          $display("FAIL reset_row%0d t=%0d: got %0d/%0d expected 0/0", k+1, t, row_r[k], row_i[k]);
        end
      end
      n_cmp++;
      if ({row_f[0], row_f[1], row_f[2]} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_flags t=%0d: got %b%b%b expected 000", t, row_f[0], row_f[1], row_f[2]);
      end
      n_cmp++;
      if (s_ready !== 1'b1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ready_busy t=%0d: got s_ready=%b busy=%b expected 1/0", t, s_ready, busy);
      end
    end
`ifdef QRD_SKEW_BUBBLE_CNT_EN
    n_cmp++;
    if (bubble_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt);
    end
`endif
  endtask

  task automatic test_single_matrix();
    logic signed [W-1:0] er;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_col(c);
      tick(1'b0, 1'b1);
    end
    for (int n = 1; n <= 8; n++) begin
      tick(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
        er = ev(n - 1 - k, k, 4);
        n_cmp++;
        if (row_r[k] !== er || row_i[k] !== -er) begin
          n_bad++;
          $display("FAIL single_row%0d beat%0d: got %0d/%0d expected %0d/%0d", k+1, n, row_r[k], row_i[k], er, -er);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (row_f[k] !== ef(n - 1 - k, 4)) begin
          n_bad++;
          $display("FAIL single_flag%0d beat%0d: got %b expected %b", k+1, n, row_f[k], ef(n - 1 - k, 4));
        end
      end
      n_cmp++;
      if (busy !== logic'(n <= 7)) begin
        n_bad++;
        $display("FAIL single_busy beat%0d: got %b expected %b", n, busy, n <= 7);
      end
      repeat (ITER - 1) tick(1'b0, 1'b0);
      er = ev(n - 1, 0, 4);
      n_cmp++;
      if (row_r[0] !== er) begin
        n_bad++;
        $display("FAIL single_hold beat%0d: got %0d expected %0d", n, row_r[0], er);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_v [4] = '{11, 21, 31, 41};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_ready_before_push%0d: got %b expected 1", c, s_ready);
      end
      drive_col(c);
      tick(1'b0, 1'b1);
    end
    n_cmp++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_full: got s_ready=%b busy=%b expected 0/1", s_ready, busy);
    end
    drive_col(9);
    tick(1'b0, 1'b1);
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_still_full: got %b expected 0", s_ready);
    end
    // Pop in the full cycle; column 9 must not slip in
    drive_col(9);
    tick(1'b1, 1'b1);
    n_cmp++;
    if (s_ready !== 1'b1 || row_r[0] !== W'(1) || row_f[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_first_pop: got ready=%b row1=%0d f=%b expected 1/1/1", s_ready, row_r[0], row_f[0]);
    end
    drive_col(4);
    tick(1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if (row_r[0] !== W'(exp_v[n]) || row_f[0] !== logic'(n == 3)) begin
        n_bad++;
        $display("FAIL bp_seq%0d: got %0d f=%b expected %0d f=%b", n, row_r[0], row_f[0], exp_v[n], n == 3);
      end
    end
  endtask

  task automatic test_starvation();
    int exp_r1 [7] = '{1, 11, 0, 0, 21, 31, 1};
    int exp_r2 [7] = '{0, 2, 12, 0, 0, 22, 32};
    logic exp_f1 [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    drive_col(0); tick(1'b0, 1'b1);
    drive_col(1); tick(1'b0, 1'b1);
    for (int n = 0; n < 7; n++) begin
      if (n == 4) begin
        drive_col(2); tick(1'b0, 1'b1);
        drive_col(3); tick(1'b0, 1'b1);
      end
      if (n == 6) begin
        drive_col(0); tick(1'b0, 1'b1);
      end
      tick(1'b1, 1'b0);
      n_cmp++;
      if (row_r[0] !== W'(exp_r1[n]) || row_f[0] !== exp_f1[n]) begin
        n_bad++;
        $display("FAIL starve_row1 adv%0d: got %0d f=%b expected %0d f=%b", n+1, row_r[0], row_f[0], exp_r1[n], exp_f1[n]);
      end
      n_cmp++;
      if (row_r[1] !== W'(exp_r2[n])) begin
        n_bad++;
        $display("FAIL starve_row2 adv%0d: got %0d expected %0d", n+1, row_r[1], exp_r2[n]);
      end
    end
`ifdef QRD_SKEW_BUBBLE_CNT_EN
    n_cmp++;
    if (bubble_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL starve_bubble_cnt: got %0d expected 2", bubble_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] er;
    do_reset();
    for (int n = 1; n <= 13; n++) begin
      if (n <= 8) begin
        drive_col(n - 1);
        n_cmp++;
        if (s_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ready beat%0d: got %b expected 1", n, s_ready);
        end
      end
      tick(1'b1, logic'(n <= 8));
      for (int k = 0; k < 4; k++) begin
        er = ev(n - 2 - k, k, 8);
        n_cmp++;
        if (row_r[k] !== er || row_i[k] !== -er) begin
          n_bad++;
          $display("FAIL b2b_row%0d beat%0d: got %0d/%0d expected %0d/%0d", k+1, n, row_r[k], row_i[k], er, -er);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (row_f[k] !== ef(n - 2 - k, 8)) begin
          n_bad++;
          $display("FAIL b2b_flag%0d beat%0d: got %b expected %b", k+1, n, row_f[k], ef(n - 2 - k, 8));
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drained_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_col(c);
      tick(1'b0, 1'b1);
    end
    repeat (3) tick(1'b1, 1'b0);
    n_cmp++;
    if (row_r[2] !== W'(3) || row_f[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre_row3: got %0d f=%b expected 3 f=1", row_r[2], row_f[2]);
    end
    rst_n = 1'b0;
    tick(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (row_r[k] !== '0 || row_i[k] !== '0) begin
        n_bad++;
        $display("FAIL mid_rst_row%0d: got %0d/%0d expected 0/0", k+1, row_r[k], row_i[k]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || {row_f[0], row_f[1], row_f[2]} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_rst_status: got busy=%b ready=%b flags=%b%b%b expected 0/1/000", busy, s_ready, row_f[0], row_f[1], row_f[2]);
    end
    drive_col(0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    n_cmp++;
    if (row_r[0] !== W'(1) || row_f[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_restart: got %0d f=%b expected 1 f=1", row_r[0], row_f[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      col_r[k] = '0;
      col_i[k] = '0;
    end
    test_reset();
    test_single_matrix();
    test_backpressure();
    test_starvation();
    test_back_to_back();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
